arb_rr_8: RTL

Eight-requester round-robin arbiter that grants exclusive tenure of one shared resource, such as a queue write port or a crossbar output, to one of eight ports. Each grant is held until the owner releases it, drops its request, or exceeds a programmable hold limit. It sits between per-port request logic and the shared datapath. Its outputs are the one-hot select and the binary index that drive the resource mux.

---
 rtl/arb_pkg.sv | 15 +
 rtl/prio_enc_8.sv | 21 ++
 rtl/arb_rr_8.sv | 104 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the eight-port round-robin arbiter: port vectors, indices and FSM states.
package arb_pkg;

    localparam int NPORT = 8;
    localparam int IDX_W = 3;

    typedef logic [NPORT-1:0] port_vec_t;
    typedef logic [IDX_W-1:0] port_idx_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

endpackage

// File: rtl/prio_enc_8.sv
// Lowest-index-first 8-to-3 priority encoder; idx_o is 0 (never X) when nothing is set.
module prio_enc_8
    import arb_pkg::*;
(
    input  port_vec_t vec_i,
    output port_idx_t idx_o,
    output logic      vld_o
);

    always_comb begin
        idx_o = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = port_idx_t'(i);
            end
        end
    end

    assign vld_o = |vec_i;

endmodule

// File: rtl/arb_rr_8.sv
// Eight-port round-robin arbiter granting held tenure of a shared resource, with an
// optional hold-limit timeout that revokes the grant and re-arbitrates in the same cycle.
module arb_rr_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] rel,
    output logic [7:0] gnt,
    output logic       gnt_vld,
    output logic [2:0] gnt_idx,
    output logic       revoke
);

    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    arb_state_e       state_q;
    port_idx_t        ptr_q;
    port_idx_t        idx_q;
    port_vec_t        gnt_q;
    logic             revoke_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    port_vec_t above_mask;
    port_vec_t masked;
    port_idx_t msk_idx;
    port_idx_t raw_idx;
    port_idx_t win_idx;
    logic      msk_vld;
    logic      raw_vld;
    port_vec_t gnt_d;
    logic      released;
    logic      timeout;
    logic      tenure_end;

    // Search starts just above the last owner, so that owner gets lowest priority.
    always_comb begin
        above_mask = '0;
        for (int i = 0; i < NPORT; i++) begin
            above_mask[i] = (i > int'(ptr_q));
        end
    end

    assign masked = req & above_mask;

    prio_enc_8 u_enc_masked (
        .vec_i (masked),
        .idx_o (msk_idx),
        .vld_o (msk_vld)
    );

    prio_enc_8 u_enc_raw (
        .vec_i (req),
        .idx_o (raw_idx),
        .vld_o (raw_vld)
    );

    assign win_idx    = msk_vld ? msk_idx : raw_idx;
    assign gnt_d      = port_vec_t'(1) << win_idx;
    assign cnt_d      = cnt_q + CNT_W'(1);
    assign released   = rel[idx_q] | ~req[idx_q];
    assign timeout    = (MAX_HOLD != 0) && (cnt_q == CNT_LAST);
    assign tenure_end = (state_q == ARB_OWNED) && (released || timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= 3'd7;
            idx_q    <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            revoke_q <= 1'b0;
        end else begin
            // A release in the timeout cycle wins, so revoke marks only forced ends.
            revoke_q <= tenure_end && timeout && !released;
            if (state_q == ARB_IDLE || tenure_end) begin
                cnt_q <= '0;
                if (raw_vld) begin
                    state_q <= ARB_OWNED;
                    ptr_q   <= win_idx;
                    idx_q   <= win_idx;
                    gnt_q   <= gnt_d;
                end else begin
                    state_q <= ARB_IDLE;
                    idx_q   <= '0;
                    gnt_q   <= '0;
                end
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = |gnt_q;
    assign gnt_idx = idx_q;
    assign revoke  = revoke_q;

endmodule
